// File: rtl/rx_fifo_pkg.sv
// Shared definitions for the RX frame FIFO: address sizing, write-FSM
// state encodings and the field layout of a stored RAM word.
package rx_fifo_pkg;

  // Write-side FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // RAM word layout: {tuser, tlast, tdata}, tdata starting at bit 0
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned word_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

  function automatic int unsigned word_last_bit(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned word_user_bit(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/rx_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the storage or read register so it maps onto block RAM.
module rx_sdp_ram #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its value while i_re is low
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward (or cut-through) RX frame FIFO. Frames are written
// speculatively at wr_cur and only become readable once wr_ptr is
// advanced; bad or overflowed frames are discarded by rewinding wr_cur.
module rx_frame_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned FRAME_MODE     = 1,
  parameter int unsigned DROP_BAD_FRAME = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    good_frame,
  output logic                    drop_bad,
  output logic                    drop_overflow
);

  localparam int unsigned ADDR_W   = addr_w(DEPTH);
  localparam int unsigned WORD_W   = word_w(DATA_WIDTH);
  localparam int unsigned LAST_BIT = word_last_bit(DATA_WIDTH);
  localparam int unsigned USER_BIT = word_user_bit(DATA_WIDTH);
  localparam bit          STRIP_USER = (FRAME_MODE != 0) && (DROP_BAD_FRAME != 0);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_wr_cur;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_good;
  logic              r_drop_bad;
  logic              r_drop_ovf;
  logic              r_ram_vld;
  logic              r_out_vld;
  logic [WORD_W-1:0] r_out_word;

  logic [ADDR_W:0]   w_used;
  logic [ADDR_W:0]   w_cur_inc;
  logic              w_full;
  logic              w_empty;
  logic              w_we;
  logic              w_re;
  logic              w_out_load;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;

  // Used words never exceed DEPTH, so the MSB alone flags full
  assign w_used    = r_wr_cur - r_rd_ptr;
  assign w_full    = w_used[ADDR_W];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_cur_inc = r_wr_cur + 1'b1;

  assign w_we = s_axis_tvalid && !w_full &&
                ((FRAME_MODE == 0) || (r_state != ST_DROP));

  // Pack the stored word; tuser is cleared when bad frames never reach the output
  always_comb begin
    w_wdata = '0;
    w_wdata[DATA_WIDTH-1:0] = s_axis_tdata;
    w_wdata[LAST_BIT]       = s_axis_tlast;
    w_wdata[USER_BIT]       = STRIP_USER ? 1'b0 : s_axis_tuser;
  end

  // Write-side pointer management, commit/discard decisions and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_wr_cur   <= '0;
      r_good     <= 1'b0;
      r_drop_bad <= 1'b0;
      r_drop_ovf <= 1'b0;
    end else begin
      r_good     <= 1'b0;
      r_drop_bad <= 1'b0;
      r_drop_ovf <= 1'b0;
      if (FRAME_MODE == 0) begin
        if (s_axis_tvalid) begin
          if (w_full) begin
            r_drop_ovf <= 1'b1;
          end else begin
            r_wr_cur <= w_cur_inc;
            r_wr_ptr <= w_cur_inc;
            r_good   <= s_axis_tlast;
          end
        end
      end else if (s_axis_tvalid) begin
        if ((r_state == ST_DROP) || w_full) begin
          if (s_axis_tlast) begin
            r_wr_cur   <= r_wr_ptr;
            r_drop_ovf <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_state <= ST_DROP;
          end
        end else if (s_axis_tlast) begin
          if (s_axis_tuser && (DROP_BAD_FRAME != 0)) begin
            r_wr_cur   <= r_wr_ptr;
            r_drop_bad <= 1'b1;
          end else begin
            r_wr_cur <= w_cur_inc;
            r_wr_ptr <= w_cur_inc;
            r_good   <= 1'b1;
          end
          r_state <= ST_IDLE;
        end else begin
          r_wr_cur <= w_cur_inc;
          r_state  <= ST_ACCUM;
        end
      end
    end
  end

  // Two-stage read path: RAM read register feeds the output register.
  // A new RAM read is issued only when the read register will be free,
  // which keeps one beat per cycle under tready=1 and holds under stall.
  assign w_out_load = r_ram_vld && (!r_out_vld || m_axis_tready);
  assign w_re       = !w_empty && (!r_ram_vld || w_out_load);

  // Read pointer, read-register occupancy and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_ram_vld  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_word <= '0;
    end else begin
      if (w_re) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_vld <= w_re || (r_ram_vld && !w_out_load);
      if (w_out_load) begin
        r_out_word <= w_rdata;
        r_out_vld  <= 1'b1;
      end else if (r_out_vld && m_axis_tready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  rx_sdp_ram #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_cur[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign m_axis_tdata  = r_out_word[DATA_WIDTH-1:0];
  assign m_axis_tlast  = r_out_word[LAST_BIT];
  assign m_axis_tuser  = r_out_word[USER_BIT];
  assign m_axis_tvalid = r_out_vld;
  assign level         = r_wr_ptr - r_rd_ptr;
  assign good_frame    = r_good;
  assign drop_bad      = r_drop_bad;
  assign drop_overflow = r_drop_ovf;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo: a DEPTH=16 store-and-forward instance
// and a DEPTH=8 cut-through instance sharing one clock and reset.
`timescale 1ns/1ps
module tb_rx_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Store-and-forward instance signals
  logic [7:0] s_data;
  logic       s_valid, s_last, s_user, m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_user;
  logic [4:0] level;
  logic       good, dbad, dovf;

  // Cut-through instance signals
  logic [7:0] c_sdata;
  logic       c_svalid, c_slast, c_suser, c_ready;
  logic [7:0] c_mdata;
  logic       c_mvalid, c_mlast, c_muser;
  logic [3:0] c_level;
  logic       c_good, c_dbad, c_dovf;

  rx_frame_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FRAME_MODE(1), .DROP_BAD_FRAME(1)) u_sf (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .level(level), .good_frame(good), .drop_bad(dbad), .drop_overflow(dovf)
  );

  rx_frame_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FRAME_MODE(0), .DROP_BAD_FRAME(1)) u_ct (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(c_sdata), .s_axis_tvalid(c_svalid), .s_axis_tlast(c_slast), .s_axis_tuser(c_suser),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_ready),
    .m_axis_tlast(c_mlast), .m_axis_tuser(c_muser),
    .level(c_level), .good_frame(c_good), .drop_bad(c_dbad), .drop_overflow(c_dovf)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_good = 0, n_bad = 0, n_ovf = 0, n_cgood = 0, n_covf = 0;
  int max_level = 0, n_hold_err = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [9:0] prev_w = '0;
  logic [9:0] sf_q[$];
  logic [9:0] ct_q[$];
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output capture, status pulse counting and stall-stability tracking
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) sf_q.push_back({m_user, m_last, m_data});
      if (c_mvalid && c_ready) ct_q.push_back({c_muser, c_mlast, c_mdata});
      if (prev_v && !prev_r && (!m_valid || ({m_user, m_last, m_data} != prev_w))) n_hold_err++;
      if (good) n_good++;
      if (dbad) n_bad++;
      if (dovf) n_ovf++;
      if (c_good) n_cgood++;
      if (c_dovf) n_covf++;
      if (int'(level) > max_level) max_level = int'(level);
    end
    prev_v = m_valid;
    prev_r = m_ready;
    prev_w = {m_user, m_last, m_data};
  end

  task automatic sf_beat(input logic [7:0] d, input logic last, input logic user);
    s_data = d; s_valid = 1'b1; s_last = last; s_user = user;
    @(posedge clk); #1;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
  endtask

  task automatic sf_frame(input int len, input logic [7:0] base, input logic user);
    for (int i = 0; i < len; i++)
      sf_beat(base + 8'(i), (i == len - 1), (i == len - 1) ? user : 1'b0);
  endtask

  task automatic exp_frame(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++)
      exp_q.push_back({1'b0, (i == len - 1), base + 8'(i)});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_q(input string tag, input bit use_ct);
    logic [9:0] got[$];
    if (use_ct) got = ct_q; else got = sf_q;
    check({tag, " beat count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s beat%0d", tag, i), got[i], exp_q[i]);
    exp_q.delete();
    if (use_ct) ct_q.delete(); else sf_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b0;
    c_sdata = '0; c_svalid = 1'b0; c_slast = 1'b0; c_suser = 1'b0; c_ready = 1'b0;
    cycles(3);
    check("rst m_valid", m_valid, 0);
    check("rst level", level, 0);
    check("rst ct m_valid", c_mvalid, 0);
    check("rst ct level", c_level, 0);
    rst_n = 1'b1;
    cycles(1);

    // T1: 10-byte good frame, latency from tlast to first tvalid
    m_ready = 1'b1;
    sf_frame(10, 8'h00, 1'b0);
    check("t1 good at N", good, 1);
    check("t1 level at N", level, 10);
    check("t1 valid at N", m_valid, 0);
    cycles(1);
    check("t1 valid at N+1", m_valid, 0);
    check("t1 level at N+1", level, 9);
    cycles(1);
    check("t1 valid at N+2", m_valid, 1);
    check("t1 data at N+2", m_data, 8'h00);
    cycles(12);
    exp_frame(10, 8'h00);
    cmp_q("t1", 1'b0);
    check("t1 good count", n_good, 1);
    check("t1 level end", level, 0);

    // T2: bad frame dropped, following good frame passes
    n_good = 0; n_bad = 0;
    sf_frame(6, 8'h20, 1'b1);
    sf_frame(4, 8'h30, 1'b0);
    cycles(12);
    exp_frame(4, 8'h30);
    cmp_q("t2", 1'b0);
    check("t2 drop_bad count", n_bad, 1);
    check("t2 good count", n_good, 1);
    check("t2 level end", level, 0);

    // T3: overflow while stalled; 12-byte frame leaves 2 words in the read
    // pipeline and 10 in RAM, so 6 more fit and the 8-byte frame overflows
    m_ready = 1'b0; n_good = 0; n_ovf = 0;
    sf_frame(12, 8'h40, 1'b0);
    cycles(3);
    check("t3 level after commit", level, 10);
    check("t3 valid stalled", m_valid, 1);
    check("t3 data stalled", m_data, 8'h40);
    sf_frame(8, 8'h60, 1'b0);
    cycles(1);
    check("t3 overflow count", n_ovf, 1);
    check("t3 good count", n_good, 1);
    check("t3 level after drop", level, 10);
    m_ready = 1'b1;
    cycles(16);
    exp_frame(12, 8'h40);
    cmp_q("t3", 1'b0);
    check("t3 level end", level, 0);

    // T4: back-to-back frames with tready toggling every cycle
    n_good = 0; max_level = 0; n_hold_err = 0; m_ready = 1'b1;
    fork
      begin
        sf_frame(5, 8'h80, 1'b0);
        sf_frame(5, 8'h90, 1'b0);
      end
      begin
        repeat (40) begin
          m_ready = ~m_ready;
          cycles(1);
        end
      end
    join
    m_ready = 1'b1;
    cycles(8);
    exp_frame(5, 8'h80);
    exp_frame(5, 8'h90);
    cmp_q("t4", 1'b0);
    check("t4 good count", n_good, 2);
    check("t4 level bound", (max_level <= 10), 1);
    check("t4 stall hold errors", n_hold_err, 0);

    // T5: reset mid-frame with a committed frame waiting at the output
    m_ready = 1'b0;
    sf_frame(2, 8'hB0, 1'b0);
    sf_beat(8'hA0, 1'b0, 1'b0);
    sf_beat(8'hA1, 1'b0, 1'b0);
    sf_beat(8'hA2, 1'b0, 1'b0);
    check("t5 valid before reset", m_valid, 1);
    rst_n = 1'b0;
    #2;
    check("t5 rst m_valid", m_valid, 0);
    check("t5 rst m_data", m_data, 0);
    check("t5 rst m_last", m_last, 0);
    check("t5 rst m_user", m_user, 0);
    check("t5 rst level", level, 0);
    check("t5 rst pulses", {good, dbad, dovf}, 0);
    cycles(1);
    sf_q.delete();
    rst_n = 1'b1;
    cycles(1);
    m_ready = 1'b1; n_good = 0;
    sf_frame(4, 8'hC0, 1'b0);
    cycles(10);
    exp_frame(4, 8'hC0);
    cmp_q("t5", 1'b0);
    check("t5 good count", n_good, 1);

    // T6: cut-through, DEPTH=8, stalled; 2 words sit in the read pipeline,
    // so beats 0..9 are stored and beats 10 and 11 each overflow
    c_ready = 1'b0; n_cgood = 0; n_covf = 0;
    for (int i = 0; i < 12; i++) begin
      c_sdata = 8'hD0 + 8'(i);
      c_svalid = 1'b1;
      c_slast = (i == 3) || (i == 7) || (i == 9);
      cycles(1);
      if (i == 1) check("t6 valid at N+1", c_mvalid, 0);
      if (i == 2) begin
        check("t6 valid at N+2", c_mvalid, 1);
        check("t6 data at N+2", c_mdata, 8'hD0);
      end
    end
    c_svalid = 1'b0; c_slast = 1'b0; c_sdata = '0;
    cycles(1);
    check("t6 overflow count", n_covf, 2);
    check("t6 good count", n_cgood, 3);
    check("t6 level", c_level, 8);
    c_ready = 1'b1;
    cycles(14);
    for (int i = 0; i < 10; i++)
      exp_q.push_back({1'b0, (i == 3) || (i == 7) || (i == 9), 8'hD0 + 8'(i)});
    cmp_q("t6", 1'b1);
    check("t6 level end", c_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
